// File: rtl/mc8051_intc.sv
// mc8051_intc: prioritised, nesting interrupt controller for the mc8051 core.
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   irq[NUM_SRC]            - synchronous active-high source requests
//   mem_sfr_n/we_n/rd_n     - SFR bus select and strobes (active-low)
//   mem_addr, mem_wdata     - SFR address and write data
//   sfr_rdata, sfr_rdy      - read data and one-cycle completion pulse (hits only)
//   int_req_n, int_so_num   - registered request and winning vector to the core
//   int_ack_n, int_reti     - core acknowledge (low pulse) and return-from-interrupt
//   in_service[PRIO_LEVELS] - in-service flag per priority level
//
// Handshake: int_req_n low means int_so_num holds a winner whose priority is
// above the highest in-service level. An ack (int_ack_n=0) is accepted only
// while int_req_n is low; it marks the winner's level in service, clears its
// edge pending bit and forces int_req_n high for the following cycle. A reti
// pops the highest in-service level; a reti and ack together pop then push.
module mc8051_intc #(
  parameter int         NUM_SRC     = 8,
  parameter int         PRIO_LEVELS = 2,
  parameter logic [7:0] SFR_BASE    = 8'hC0,
  parameter logic [7:0] VEC_BASE    = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     irq,
  input  logic                   mem_sfr_n,
  input  logic                   mem_we_n,
  input  logic                   mem_rd_n,
  input  logic [7:0]             mem_addr,
  input  logic [7:0]             mem_wdata,
  output logic [7:0]             sfr_rdata,
  output logic                   sfr_rdy,
  output logic                   int_req_n,
  output logic [7:0]             int_so_num,
  input  logic                   int_ack_n,
  input  logic                   int_reti,
  output logic [PRIO_LEVELS-1:0] in_service
);

  localparam int NB       = (NUM_SRC + 7) / 8;
  localparam int PB       = (NUM_SRC + 3) / 4;
  localparam int OFF_EN   = 1;
  localparam int OFF_EDGE = 1 + NB;
  localparam int OFF_PEND = 1 + 2 * NB;
  localparam int OFF_PRIO = 1 + 3 * NB;
  localparam int MAP_SZ   = OFF_PRIO + PB;
  localparam logic [1:0] PMAX = 2'(PRIO_LEVELS - 1);

  logic                      r_ea;
  logic [NUM_SRC-1:0]        r_en, r_edge, r_pend, r_irq_q;
  logic [NUM_SRC-1:0][1:0]   r_prio;
  logic                      r_acc_q;
  logic                      r_req_n;
  logic [7:0]                r_so_num;
  logic [4:0]                r_win_idx;
  logic [PRIO_LEVELS-1:0]    r_isr;
  logic                      r_rdy;
  logic [7:0]                r_rdata;

  logic [7:0]                w_off, w_rd_byte;
  logic                      w_strobe, w_hit, w_start, w_wr, w_rd;
  logic [NB*8-1:0]           w_en_img, w_edge_img, w_pend_img;
  logic [PB*8-1:0]           w_prio_img;
  logic [NUM_SRC-1:0]        w_pend_eff, w_elig, w_set, w_clr;
  logic                      w_found, w_cur_vld, w_req, w_ack;
  logic [4:0]                w_win_idx;
  logic [1:0]                w_win_prio, w_cur_lvl, w_ack_prio;
  logic [PRIO_LEVELS-1:0]    w_isr_nxt;

  function automatic logic [1:0] f_clip(input logic [1:0] v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  // SFR access detection: one access per strobe assertion
  assign w_off    = mem_addr - SFR_BASE;
  assign w_strobe = ~mem_sfr_n & (~mem_we_n | ~mem_rd_n);
  assign w_hit    = (w_off < 8'(MAP_SZ));
  assign w_start  = w_strobe & ~r_acc_q & w_hit;
  assign w_wr     = w_start & ~mem_we_n;
  assign w_rd     = w_start & mem_we_n;

  // Byte images of the per-source registers; bits of absent sources stay 0
  always_comb begin
    w_en_img   = '0;
    w_edge_img = '0;
    w_pend_img = '0;
    w_prio_img = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_en_img[k]          = r_en[k];
      w_edge_img[k]        = r_edge[k];
      w_pend_img[k]        = r_edge[k] ? r_pend[k] : irq[k];
      w_prio_img[2*k +: 2] = r_prio[k];
    end
  end

  always_comb begin
    w_rd_byte = '0;
    if (w_off == 8'd0) w_rd_byte = {r_ea, 7'b0};
    for (int j = 0; j < NB; j++) begin
      if (w_off == 8'(OFF_EN + j))   w_rd_byte = w_en_img[j*8 +: 8];
      if (w_off == 8'(OFF_EDGE + j)) w_rd_byte = w_edge_img[j*8 +: 8];
      if (w_off == 8'(OFF_PEND + j)) w_rd_byte = w_pend_img[j*8 +: 8];
    end
    for (int j = 0; j < PB; j++) begin
      if (w_off == 8'(OFF_PRIO + j)) w_rd_byte = w_prio_img[j*8 +: 8];
    end
  end

  // Level sources resolve from the registered irq so both modes share latency
  assign w_pend_eff = (r_edge & r_pend) | (~r_edge & r_irq_q);
  assign w_elig     = w_pend_eff & r_en & {NUM_SRC{r_ea}};

  // Strict '>' while scanning upward keeps the lowest index on a tie
  always_comb begin
    w_found    = 1'b0;
    w_win_idx  = '0;
    w_win_prio = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_elig[k] && (!w_found || r_prio[k] > w_win_prio)) begin
        w_found    = 1'b1;
        w_win_idx  = 5'(k);
        w_win_prio = r_prio[k];
      end
    end
  end

  always_comb begin
    w_cur_vld = 1'b0;
    w_cur_lvl = '0;
    for (int l = 0; l < PRIO_LEVELS; l++) begin
      if (r_isr[l]) begin
        w_cur_vld = 1'b1;
        w_cur_lvl = 2'(l);
      end
    end
  end

  assign w_req = w_found && (!w_cur_vld || w_win_prio > w_cur_lvl);
  assign w_ack = ~int_ack_n & ~r_req_n;

  // Ack side effects apply to the source behind the registered vector
  always_comb begin
    w_ack_prio = '0;
    w_clr      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_win_idx == 5'(k)) begin
        w_ack_prio = r_prio[k];
        w_clr[k]   = w_ack & r_edge[k];
      end
      if (w_wr && w_off == 8'(OFF_PEND + k / 8) && mem_wdata[k % 8]) w_clr[k] = 1'b1;
    end
  end

  assign w_set = irq & ~r_irq_q & r_edge;

  // Pop (reti) before push (ack)
  always_comb begin
    w_isr_nxt = r_isr;
    for (int l = 0; l < PRIO_LEVELS; l++) begin
      if (int_reti && w_cur_vld && w_cur_lvl == 2'(l)) w_isr_nxt[l] = 1'b0;
    end
    for (int l = 0; l < PRIO_LEVELS; l++) begin
      if (w_ack && w_ack_prio == 2'(l)) w_isr_nxt[l] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ea      <= 1'b0;
      r_en      <= '0;
      r_edge    <= '0;
      r_pend    <= '0;
      r_irq_q   <= '0;
      r_prio    <= '0;
      r_acc_q   <= 1'b0;
      r_req_n   <= 1'b1;
      r_so_num  <= VEC_BASE;
      r_win_idx <= '0;
      r_isr     <= '0;
      r_rdy     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_irq_q <= irq;
      r_acc_q <= w_strobe;
      r_rdy   <= w_start;
      r_rdata <= w_rd ? w_rd_byte : 8'h00;
      // Set beats clear; latched bits only survive in edge mode
      r_pend  <= ((r_pend & ~w_clr) | w_set) & r_edge;
      r_isr   <= w_isr_nxt;
      r_req_n <= w_ack ? 1'b1 : ~w_req;
      if (w_found) begin
        r_so_num  <= VEC_BASE + {3'b000, w_win_idx};
        r_win_idx <= w_win_idx;
      end
      if (w_wr) begin
        if (w_off == 8'd0) r_ea <= mem_wdata[7];
        for (int k = 0; k < NUM_SRC; k++) begin
          if (w_off == 8'(OFF_EN + k / 8))   r_en[k]   <= mem_wdata[k % 8];
          if (w_off == 8'(OFF_EDGE + k / 8)) r_edge[k] <= mem_wdata[k % 8];
          if (w_off == 8'(OFF_PRIO + k / 4)) r_prio[k] <= f_clip(mem_wdata[2*(k%4) +: 2]);
        end
      end
    end
  end

  assign sfr_rdata  = r_rdata;
  assign sfr_rdy    = r_rdy;
  assign int_req_n  = r_req_n;
  assign int_so_num = r_so_num;
  assign in_service = r_isr;

endmodule

// File: tb/tb_mc8051_intc.sv
// Directed bench for mc8051_intc: an 8-source/2-level instance (VEC_BASE=03)
// plus a 32-source instance sharing the SFR bus for the wide-index smoke test.
module tb_mc8051_intc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq;
  logic [31:0] irq32;
  logic        mem_sfr_n, mem_we_n, mem_rd_n;
  logic [7:0]  mem_addr, mem_wdata;
  logic        int_ack_n, int_reti;

  logic [7:0]  sfr_rdata, int_so_num;
  logic        sfr_rdy, int_req_n;
  logic [1:0]  in_service;

  logic [7:0]  d32_rdata, d32_so_num;
  logic        d32_rdy, d32_req_n;
  logic [1:0]  d32_isr;

  int n_checks = 0;
  int n_err    = 0;

  mc8051_intc #(.NUM_SRC(8), .PRIO_LEVELS(2), .SFR_BASE(8'hC0), .VEC_BASE(8'h03)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .mem_sfr_n(mem_sfr_n), .mem_we_n(mem_we_n), .mem_rd_n(mem_rd_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sfr_rdata(sfr_rdata), .sfr_rdy(sfr_rdy),
    .int_req_n(int_req_n), .int_so_num(int_so_num),
    .int_ack_n(int_ack_n), .int_reti(int_reti), .in_service(in_service)
  );

  mc8051_intc #(.NUM_SRC(32), .PRIO_LEVELS(2), .SFR_BASE(8'hC0), .VEC_BASE(8'h03)) dut32 (
    .clk(clk), .reset_n(reset_n), .irq(irq32),
    .mem_sfr_n(mem_sfr_n), .mem_we_n(mem_we_n), .mem_rd_n(mem_rd_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sfr_rdata(d32_rdata), .sfr_rdy(d32_rdy),
    .int_req_n(d32_req_n), .int_so_num(d32_so_num),
    .int_ack_n(int_ack_n), .int_reti(int_reti), .in_service(d32_isr)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    mem_sfr_n = 1'b0; mem_we_n = 1'b0; mem_addr = a; mem_wdata = d;
    tick();
    mem_sfr_n = 1'b1; mem_we_n = 1'b1;
    check("wr_rdy", sfr_rdy, 1);
    check("wr_rdata", sfr_rdata, 0);
    tick();
  endtask

  task automatic sfr_rd(input logic [7:0] a, output logic [7:0] d);
    mem_sfr_n = 1'b0; mem_rd_n = 1'b0; mem_addr = a;
    tick();
    mem_sfr_n = 1'b1; mem_rd_n = 1'b1;
    check("rd_rdy", sfr_rdy, 1);
    d = sfr_rdata;
    tick();
  endtask

  task automatic ack();
    int_ack_n = 1'b0;
    tick();
    int_ack_n = 1'b1;
  endtask

  task automatic reti();
    int_reti = 1'b1;
    tick();
    int_reti = 1'b0;
  endtask

  logic [7:0] rd;
  int         cnt;

  initial begin
    reset_n = 1'b0; irq = '0; irq32 = '0;
    mem_sfr_n = 1'b1; mem_we_n = 1'b1; mem_rd_n = 1'b1;
    mem_addr = '0; mem_wdata = '0; int_ack_n = 1'b1; int_reti = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_req_n", int_req_n, 1);
    check("rst_so_num", int_so_num, 8'h03);
    check("rst_rdy", sfr_rdy, 0);
    check("rst_rdata", sfr_rdata, 0);
    check("rst_isr", in_service, 0);
    reset_n = 1'b1;
    tick();

    // Basic edge request and ack
    sfr_wr(8'hC0, 8'h80);
    sfr_wr(8'hC1, 8'h01);
    sfr_wr(8'hC2, 8'h01);
    irq[0] = 1'b1;              // cycle N
    tick();
    irq[0] = 1'b0;
    check("edge_req_n1", int_req_n, 1);
    tick();                     // N+2
    check("edge_req_n2", int_req_n, 0);
    check("edge_vec", int_so_num, 8'h03);
    ack();
    check("ack_req_hi", int_req_n, 1);
    check("ack_isr", in_service, 2'b01);
    sfr_rd(8'hC3, rd);
    check("ack_pend", rd, 8'h00);

    // Nesting: src5 level mode at priority 1 over src0 in service
    sfr_wr(8'hC5, 8'h04);
    sfr_wr(8'hC1, 8'h21);
    irq[5] = 1'b1;
    tick();
    tick();
    check("nest_req", int_req_n, 0);
    check("nest_vec", int_so_num, 8'h08);
    ack();
    irq[5] = 1'b0;
    check("nest_isr11", in_service, 2'b11);
    check("nest_ack_hi", int_req_n, 1);
    reti();
    check("nest_reti1", in_service, 2'b01);
    reti();
    check("nest_reti2", in_service, 2'b00);
    reti();
    check("nest_reti3", in_service, 2'b00);
    check("nest_idle", int_req_n, 1);

    // Same-level block: src1 (level 0) waits behind src0
    sfr_wr(8'hC1, 8'h03);
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick();
    check("blk_req0", int_req_n, 0);
    ack();
    check("blk_isr", in_service, 2'b01);
    irq[1] = 1'b1;
    repeat (4) tick();
    check("blk_held", int_req_n, 1);
    reti();                     // reti at R
    check("blk_r1", int_req_n, 1);
    tick();                     // R+2
    check("blk_r2", int_req_n, 0);
    check("blk_vec", int_so_num, 8'h04);
    ack();
    irq[1] = 1'b0;
    check("blk_isr2", in_service, 2'b01);
    tick();
    reti();
    check("blk_done", in_service, 2'b00);

    // Tie at the same level, then raise src6 to level 1
    sfr_wr(8'hC1, 8'h44);
    irq[2] = 1'b1; irq[6] = 1'b1;
    tick();
    tick();
    check("tie_req", int_req_n, 0);
    check("tie_vec", int_so_num, 8'h05);
    sfr_wr(8'hC5, 8'h10);
    check("prio_req", int_req_n, 0);
    check("prio_vec", int_so_num, 8'h09);
    irq[2] = 1'b0; irq[6] = 1'b0;
    tick();
    tick();
    check("tie_drop", int_req_n, 1);

    // SFR edge cases
    sfr_wr(8'hC4, 8'hFF);
    sfr_rd(8'hC4, rd);
    check("prio_clip", rd, 8'h55);
    sfr_wr(8'hC4, 8'h00);

    mem_sfr_n = 1'b0; mem_rd_n = 1'b0; mem_addr = 8'hC6;
    tick();
    check("miss_rdy1", sfr_rdy, 0);
    tick();
    check("miss_rdy2", sfr_rdy, 0);
    mem_sfr_n = 1'b1; mem_rd_n = 1'b1;
    tick();

    cnt = 0;
    mem_sfr_n = 1'b0; mem_rd_n = 1'b0; mem_addr = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sfr_rdy) cnt++;
    end
    mem_sfr_n = 1'b1; mem_rd_n = 1'b1;
    tick();
    if (sfr_rdy) cnt++;
    check("held_rdy_cnt", cnt, 1);

    mem_sfr_n = 1'b0; mem_we_n = 1'b0; mem_addr = 8'hC3; mem_wdata = 8'h01;
    irq[0] = 1'b1;
    tick();
    mem_sfr_n = 1'b1; mem_we_n = 1'b1;
    irq[0] = 1'b0;
    tick();
    sfr_rd(8'hC3, rd);
    check("w1c_vs_set", rd, 8'h01);
    sfr_wr(8'hC3, 8'h01);
    sfr_rd(8'hC3, rd);
    check("w1c_clear", rd, 8'h00);

    // Reset in the middle of a nested request
    sfr_wr(8'hC5, 8'h04);
    sfr_wr(8'hC1, 8'h21);
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick();
    ack();
    irq[5] = 1'b1;
    tick();
    tick();
    check("pre_rst_req", int_req_n, 0);
    check("pre_rst_isr", in_service, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_req", int_req_n, 1);
    check("async_isr", in_service, 2'b00);
    check("async_vec", int_so_num, 8'h03);
    irq = '0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_rdy", sfr_rdy, 0);
    tick();
    sfr_rd(8'hC1, rd);
    check("post_rst_en", rd, 8'h00);

    // 32-source smoke test: src31 in level mode
    sfr_wr(8'hC0, 8'h80);
    sfr_wr(8'hC4, 8'h80);
    irq32[31] = 1'b1;
    tick();
    check("w32_req1", d32_req_n, 1);
    tick();
    check("w32_req2", d32_req_n, 0);
    check("w32_vec", d32_so_num, 8'h22);
    irq32[31] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mc8051_intc.md
# mc8051_intc

Parametrised interrupt controller for the mc8051 core. It drives the core's `int_req_n` / `int_ack_n` / `int_so_num` / `int_reti` handshake from up to 32 synchronous sources, with up to 4 priority levels and nested in-service tracking. Its control registers sit on the core's SFR bus. It replaces the fixed external request wiring in front of `mc8051_top`.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of sources, legal range 1..32.
- `PRIO_LEVELS`, default 2: priority levels and maximum nesting depth, legal range 1..4.
- `SFR_BASE`, default 8'hC0: SFR address of register offset 0.
- `VEC_BASE`, default 8'h00: `int_so_num` = `VEC_BASE` + source index (8-bit wrap).

Ports (NB = ceil(NUM_SRC/8), PB = ceil(NUM_SRC/4)):
- `clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `irq` in NUM_SRC: source requests, active-high, synchronous to `clk`.
- `mem_sfr_n` in 1: SFR space select, active-low.
- `mem_we_n` in 1: write strobe, active-low.
- `mem_rd_n` in 1: read strobe, active-low.
- `mem_addr` in 8: SFR address; the low byte of the core address.
- `mem_wdata` in 8: write data.
- `sfr_rdata` out 8: read data, valid while `sfr_rdy`=1.
- `sfr_rdy` out 1: one-cycle completion pulse for hit accesses only. It is ORed into the core's `mem_data_rdy`.
- `int_req_n` out 1: interrupt request to the core, active-low.
- `int_so_num` out 8: vector of the winning source.
- `int_ack_n` in 1: core acknowledge, a one-cycle active-low pulse.
- `int_reti` in 1: core return-from-interrupt, a one-cycle pulse.
- `in_service` out PRIO_LEVELS: in-service flag per level.

## Operation
Register map (byte offset from `SFR_BASE`):
- Offset 0, GCTL: bit7 = EA (global enable). All other bits read 0.
- Offsets 1..NB, EN: per-source enable.
- Offsets 1+NB..2NB, EDGE: 1 = rising-edge mode, 0 = level mode.
- Offsets 1+2NB..3NB, PEND:
  - Edge-mode bits are latched; writing 1 clears them.
  - Level-mode bits read raw `irq`; writes to them are ignored.
- Offsets 1+3NB..3NB+PB, PRIO: source k uses bits [2(k%4)+1 : 2(k%4)] of byte k/4.
  - A written value above PRIO_LEVELS-1 is stored as PRIO_LEVELS-1 and reads back clipped.
- Bits for nonexistent sources read 0. Offsets outside the map do not hit, and produce no `sfr_rdy`.

SFR access:
- An access starts on the first cycle that `mem_sfr_n`=0 and (`mem_we_n`=0 or `mem_rd_n`=0), with a hit address.
- A write commits at that edge.
- The next cycle, `sfr_rdy`=1 for exactly one cycle, with `sfr_rdata` = register value (reads) or 0 (writes).
- Holding the strobes low does not re-trigger the access. A new access requires the strobes to go high first.

Pending:
- Edge-mode pending sets on `irq` 0→1, where the previous value is registered.
- If a set event and a clear (ack or W1C) hit the same bit in the same cycle, set wins.

Resolution (combinational candidate, registered outputs):
- Eligible source: pending & EN & EA.
- Winner: highest PRIO, with ties broken by lowest index.
- Current level: highest set bit of `in_service`, or −1 if none.
- `int_req_n` is registered low when a winner exists with PRIO > current level. `int_so_num` is registered with the winner's vector.
- Both are re-evaluated every cycle. A vanished winner (disabled, W1C, level dropped) deasserts `int_req_n`.

Handshake:
- `int_ack_n`=0 while `int_req_n`=0 does three things:
  - sets `in_service[prio]` for the source in the registered `int_so_num`;
  - clears that source's pending bit if it is edge-mode;
  - forces `int_req_n`=1 in the next cycle.
- `int_ack_n`=0 while `int_req_n`=1 is ignored.
- `int_reti`=1 clears the highest set `in_service` bit. With `in_service` empty it is ignored.
- Ack and reti in the same cycle: pop first, then push.

## Timing
Reset values:
- `int_req_n`=1, `int_so_num`=`VEC_BASE`, `sfr_rdy`=0, `sfr_rdata`=0, `in_service`=0.
- All registers are 0: EA off, all sources disabled, level mode, priority 0, nothing pending.

Latencies:
- `irq` rising edge at cycle N → pending visible at N+1 → `int_req_n` low at N+2. Level mode has the same latency.
- Ack at T → `int_req_n`=1 at T+1 → may reassert at T+2 if a higher-level winner exists.
- SFR strobe start at cycle S → `sfr_rdy` at S+1.
- A write at S affects resolution from S+1, so `int_req_n` reflects it at S+2.

Reset asserted mid-handshake or mid-access clears all state immediately. No `sfr_rdy` is produced after reset releases.

## Test plan
- NUM_SRC=8, PRIO_LEVELS=2, VEC_BASE=8'h03. Write GCTL=80, EN=01, EDGE=01, then pulse `irq[0]` at cycle N → `int_req_n` low at N+2 with `int_so_num`=03. Ack → `int_req_n` high next cycle, PEND reads 00, `in_service`=01.
- Nesting: src0 in service at level 0; set PRIO src5=1, raise `irq[5]` (level mode) → request with vector 08. Ack → `in_service`=11. Reti → 01; second reti → 00; third reti → ignored.
- Same-level block: src0 in service; src1 also at level 0 and pending → `int_req_n` stays 1. After reti → request with vector 04 at reti+2.
- Tie and priority: src2 and src6 pending at the same level → vector of src2 wins. Raise src6 to level 1 → src6 wins within 2 cycles.
- SFR edge cases:
  - Write PRIO byte 0 with FF at PRIO_LEVELS=2 → reads back 55.
  - Access offset 6 → no `sfr_rdy`.
  - Strobe held low for 3 cycles → exactly one `sfr_rdy`.
  - W1C on PEND in the same cycle as a new edge → bit stays 1.
- Reset mid-request (`int_req_n`=0) → `int_req_n`=1 and `in_service`=0 asynchronously. NUM_SRC=32 smoke test: src31 gives vector `VEC_BASE`+31.
